mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/processor_pkg.sv | 16 +
 rtl/mem_responder_if.sv | 25 ++
 rtl/mem_array.sv | 23 ++
 rtl/mem_responder.sv | 110 +++++++++++
 tb/tb_mem_responder.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/processor_pkg.sv
// Shared processor-side constants: load/store opcodes, default data-store depth
// and the responder FSM state encoding.
package processor_pkg;

  localparam logic [5:0] OP_LW = 6'b001001;
  localparam logic [5:0] OP_SW = 6'b001010;

  localparam int DEFAULT_DEPTH = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between a load/store requester (master)
// and the memory responder (slave).
interface mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_array.sv
// Single-port DEPTH x DATA_W data store: synchronous write, combinational read.
// Contents are deliberately not reset.
module mem_array #(
  parameter  int DEPTH  = 1024,
  parameter  int DATA_W = 32,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk1,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk1) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder with a fixed WAIT_CYCLES delay.
// Define MEM_ADDR_CHECK_EN to flag (and suppress) accesses at or beyond DEPTH.
module mem_responder
  import processor_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk1,
  input  logic            rst_n,
  mem_responder_if.slave  bus
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE    = 2'(ST_IDLE);
  localparam logic [1:0] S_WAIT    = 2'(ST_WAIT);
  localparam logic [1:0] S_RESP    = 2'(ST_RESP);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          we_q, err_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          rsp_err_q;

  logic          accept, commit, req_err;
  logic          c_we, c_err;
  logic [AW-1:0] c_addr;
  logic [31:0]   c_wdata, arr_rdata;

`ifdef MEM_ADDR_CHECK_EN
  assign req_err = (bus.req_addr >= 32'(DEPTH));
`else
  // Address wraps modulo DEPTH; the high bits are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:AW];
  assign req_err        = 1'b0;
`endif

  assign accept = (state == S_IDLE) && bus.req_valid;

  // With no wait cycles the commit happens on the accept edge itself, so the
  // operands come straight from the request bus instead of the capture regs.
  assign commit = (accept && (WAIT_CYCLES == 0)) ||
                  ((state == S_WAIT) && (cnt == 4'd1));

  assign c_we    = (state == S_IDLE) ? bus.req_we            : we_q;
  assign c_err   = (state == S_IDLE) ? req_err               : err_q;
  assign c_addr  = (state == S_IDLE) ? bus.req_addr[AW-1:0]  : addr_q;
  assign c_wdata = (state == S_IDLE) ? bus.req_wdata         : wdata_q;

  mem_array #(.DEPTH(DEPTH), .DATA_W(32)) u_mem (
    .clk1  (clk1),
    .we    (commit && c_we && !c_err),
    .addr  (c_addr),
    .wdata (c_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            we_q    <= bus.req_we;
            err_q   <= req_err;
            addr_q  <= bus.req_addr[AW-1:0];
            wdata_q <= bus.req_wdata;
            if (WAIT_CYCLES == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (commit) begin
        rdata_q   <= (c_we || c_err) ? 32'd0 : arr_rdata;
        rsp_err_q <= c_err;
      end
    end
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: WAIT_CYCLES=2 instance for function, latency,
// hold, range and reset tests; WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_mem_responder;

  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk1 = ~clk1;

  mem_responder_if bus ();
  mem_responder_if bus0 ();

  mem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut (
    .clk1 (clk1), .rst_n (rst_n), .bus (bus.slave)
  );

  mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk1 (clk1), .rst_n (rst_n), .bus (bus0.slave)
  );

  // Drives one request on the WAIT_CYCLES=2 instance; returns observations only.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int lat,
                      output logic rdy_low);
    @(negedge clk1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk1); #1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    lat = 0; rdy_low = 1'b1;
    while (lat < 40) begin
      @(negedge clk1);
      lat++;
      if (bus.req_ready) rdy_low = 1'b0;
      if (bus.rsp_valid) break;
    end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk1); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk1);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", bus.rsp_rdata); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
    checks++; if (bus0.req_ready !== 1'b1 || bus0.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_dut0: ready %b valid %b want 1 0", bus0.req_ready, bus0.rsp_valid); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat; logic rl;
    xact(1'b1, 32'd5, 32'hDEADBEEF, rd, er, lat, rl);
    checks++; if (rd !== 32'd0 || er !== 1'b0) begin errors++; $display("FAIL store5_rsp: got %h/%b want 0/0", rd, er); end
    xact(1'b0, 32'd5, 32'h0, rd, er, lat, rl);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load5_rdata: got %h want deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL load5_err: got %b want 0", er); end
  endtask

  task automatic test_latency();
    logic [31:0] rd; logic er; int lat; logic rl;
    xact(1'b0, 32'd5, 32'h0, rd, er, lat, rl);
    checks++; if (lat !== 3) begin errors++; $display("FAIL latency: got %0d want 3", lat); end
    checks++; if (rl !== 1'b1) begin errors++; $display("FAIL ready_low_while_busy: got %b want 1", rl); end
  endtask

  task automatic test_patterns();
    logic [31:0] addrs [4] = '{32'd0, 32'd1023, 32'd512, 32'd7};
    logic [31:0] datas [4] = '{32'h00C0FFEE, 32'h12345678, 32'h80000001, 32'h00000077};
    logic [31:0] rd; logic er; int lat; logic rl;
    for (int i = 0; i < 4; i++) xact(1'b1, addrs[i], datas[i], rd, er, lat, rl);
    for (int i = 3; i >= 0; i--) begin
      xact(1'b0, addrs[i], 32'h0, rd, er, lat, rl);
      checks++; if (rd !== datas[i]) begin errors++; $display("FAIL pattern_load addr %0d: got %h want %h", addrs[i], rd, datas[i]); end
    end
  endtask

  task automatic test_idle_hold();
    int bad = 0;
    bus.req_we = 1'b1; bus.req_addr = 32'd7; bus.req_wdata = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk1);
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) bad++;
    end
    bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL idle_no_valid: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_hold();
    logic [31:0] rd; logic er; int lat; logic rl; int bad = 0;
    @(negedge clk1);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'd5;
    @(posedge clk1); #1 bus.req_valid = 1'b0;
    repeat (3) @(negedge clk1);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL hold_enter_resp: valid %b rdata %h want 1 deadbeef", bus.rsp_valid, bus.rsp_rdata); end
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'd9; bus.req_wdata = 32'h11112222;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk1);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEADBEEF || bus.req_ready !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL hold_stable: got %0d bad cycles want 0", bad); end
    bus.rsp_ready = 1'b1;
    @(posedge clk1); #1 bus.rsp_ready = 1'b0;
    @(negedge clk1);
    checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL no_accept_on_handshake: ready %b valid %b want 1 0", bus.req_ready, bus.rsp_valid); end
    @(posedge clk1); #1 bus.req_valid = 1'b0;
    @(negedge clk1);
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL accept_after_handshake: ready %b want 0", bus.req_ready); end
    repeat (2) @(negedge clk1);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'd0) begin
      errors++; $display("FAIL queued_store_rsp: valid %b rdata %h want 1 0", bus.rsp_valid, bus.rsp_rdata); end
    bus.rsp_ready = 1'b1;
    @(posedge clk1); #1 bus.rsp_ready = 1'b0;
    bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    xact(1'b0, 32'd9, 32'h0, rd, er, lat, rl);
    checks++; if (rd !== 32'h11112222) begin errors++; $display("FAIL load9: got %h want 11112222", rd); end
  endtask

  task automatic test_addr_range();
    logic [31:0] rd; logic er; int lat; logic rl;
    xact(1'b1, 32'd1024, 32'h00005555, rd, er, lat, rl);
`ifdef MEM_ADDR_CHECK_EN
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL oob_store: err %b rdata %h want 1 0", er, rd); end
    xact(1'b0, 32'd0, 32'h0, rd, er, lat, rl);
    checks++; if (rd !== 32'h00C0FFEE) begin errors++; $display("FAIL oob_no_write: got %h want 00c0ffee", rd); end
`else
    checks++; if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL wrap_store: err %b rdata %h want 0 0", er, rd); end
    xact(1'b0, 32'd0, 32'h0, rd, er, lat, rl);
    checks++; if (rd !== 32'h00005555) begin errors++; $display("FAIL wrap_write: got %h want 00005555", rd); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; logic rl;
    xact(1'b0, 32'd7, 32'h0, rd, er, lat, rl);
    checks++; if (rd !== 32'h00000077) begin errors++; $display("FAIL pre_reset_load7: got %h want 77", rd); end
    @(negedge clk1);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'd7; bus.req_wdata = 32'hBADBAD00;
    @(posedge clk1); #1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    @(negedge clk1);
    rst_n = 1'b0;
    @(negedge clk1);
    rst_n = 1'b1;
    @(negedge clk1);
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_ctrl: valid %b ready %b want 0 1", bus.rsp_valid, bus.req_ready); end
    checks++; if (bus.rsp_rdata !== 32'd0) begin errors++; $display("FAIL post_reset_rdata: got %h want 0", bus.rsp_rdata); end
    repeat (3) @(negedge clk1);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL abandoned_rsp: got %b want 0", bus.rsp_valid); end
    xact(1'b0, 32'd7, 32'h0, rd, er, lat, rl);
    checks++; if (rd !== 32'h00000077) begin errors++; $display("FAIL addr7_unchanged: got %h want 77", rd); end
  endtask

  task automatic test_back_to_back();
    int nv = 0; int bad = 0; logic prev;
    @(negedge clk1);
    bus0.rsp_ready = 1'b1; bus0.req_valid = 1'b1;
    bus0.req_we = 1'b1; bus0.req_addr = 32'd3; bus0.req_wdata = 32'hA5A5A5A5;
    @(negedge clk1);
    checks++; if (bus0.rsp_valid !== 1'b1 || bus0.rsp_rdata !== 32'd0) begin
      errors++; $display("FAIL b2b_store_rsp: valid %b rdata %h want 1 0", bus0.rsp_valid, bus0.rsp_rdata); end
    bus0.req_we = 1'b0;
    @(negedge clk1);
    checks++; if (bus0.rsp_valid !== 1'b0 || bus0.req_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_idle_gap: valid %b ready %b want 0 1", bus0.rsp_valid, bus0.req_ready); end
    @(negedge clk1);
    checks++; if (bus0.rsp_valid !== 1'b1 || bus0.rsp_rdata !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL b2b_load_rsp: valid %b rdata %h want 1 a5a5a5a5", bus0.rsp_valid, bus0.rsp_rdata); end
    prev = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk1);
      if (bus0.rsp_valid === prev) bad++;
      prev = bus0.rsp_valid;
      if (bus0.rsp_valid === 1'b1) nv++;
    end
    bus0.req_valid = 1'b0;
    checks++; if (nv !== 10) begin errors++; $display("FAIL b2b_count: got %0d responses want 10", nv); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_alternate: got %0d bad cycles want 0", bad); end
    @(negedge clk1);
    bus0.rsp_ready = 1'b0;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0; bus0.rsp_ready = 1'b0;
    test_reset();
    test_idle_hold();
    test_store_load();
    test_latency();
    test_patterns();
    test_hold();
    test_addr_range();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
